// File: rtl/seq_calc_pkg.sv
// -----------------------------------------------------------------------------
// seq_calc_pkg
// Shared definitions for the sequential calculator: opcode constants, FSM
// state encoding and the helper that sizes the iteration counter.
// -----------------------------------------------------------------------------
package seq_calc_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_calc_divstep.sv
// -----------------------------------------------------------------------------
// seq_calc_divstep
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
// Ports:
//   rem_in       - partial remainder from the previous step (always < divisor)
//   dividend_bit - next dividend bit, MSB first
//   divisor      - divisor (non-zero when this step is used)
//   rem_out      - new partial remainder
//   quot_bit     - quotient bit produced by this step
// -----------------------------------------------------------------------------
module seq_calc_divstep #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             quot_bit
);

   logic [WIDTH:0] shifted;

   assign shifted  = {rem_in, dividend_bit};
   assign quot_bit = (shifted >= {1'b0, divisor});
   // shifted < 2*divisor, so whichever value is kept fits in WIDTH bits.
   assign rem_out  = WIDTH'(quot_bit ? (shifted - {1'b0, divisor}) : shifted);

endmodule

// File: rtl/seq_calculator.sv
// -----------------------------------------------------------------------------
// seq_calculator
// Multi-cycle unsigned ADD/SUB/MUL/DIV unit with start/done handshake.
// ADD/SUB finish in one cycle; MUL (shift-add) and DIV (restoring) iterate
// WIDTH times. Results and flags hold until the next completion.
// Optional macro SEQCALC_EARLY_TERM_EN: MUL stops once the remaining
// multiplier bits are all zero (B==0 completes immediately).
// Ports:
//   i_clk, i_rstn        - clock (rising edge), async active-low reset
//   i_start, i_op        - request and opcode (0 ADD, 1 SUB, 2 MUL, 3 DIV)
//   i_data1, i_data2     - operand A (dividend), operand B (divisor)
//   o_busy               - high whenever the FSM is not idle
//   o_done               - one-cycle completion pulse
//   o_result, o_rem      - result (2*WIDTH) and DIV remainder (WIDTH)
//   o_div_by_zero        - DIV with B==0 flag, updated with o_done
// -----------------------------------------------------------------------------
module seq_calculator
   import seq_calc_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_start,
   input  logic [1:0]         i_op,
   input  logic [WIDTH-1:0]   i_data1,
   input  logic [WIDTH-1:0]   i_data2,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_result,
   output logic [WIDTH-1:0]   o_rem,
   output logic               o_div_by_zero
);

   localparam int             CNT_W = clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [1:0]         op_q;
   logic [2*WIDTH-1:0] a_q;     // multiplicand (shifts left) / dividend (MSB out)
   logic [WIDTH-1:0]   b_q;     // multiplier (shifts right) / divisor (held)
   logic [2*WIDTH-1:0] acc_q;   // product accumulator / quotient shift register
   logic [WIDTH-1:0]   rem_q;   // partial remainder
   logic [CNT_W-1:0]   cnt_q;

   logic [WIDTH-1:0]   step_rem;
   logic               step_qbit;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] quot_next;
   logic [2*WIDTH-1:0] sum;
   logic [WIDTH:0]     diff;
   logic               calc_last;

   seq_calc_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem_in       (rem_q),
      .dividend_bit (a_q[WIDTH-1]),
      .divisor      (b_q),
      .rem_out      (step_rem),
      .quot_bit     (step_qbit)
   );

   assign mul_next  = acc_q + (b_q[0] ? a_q : '0);
   assign quot_next = {acc_q[2*WIDTH-2:0], step_qbit};
   assign sum       = {{WIDTH{1'b0}}, i_data1} + {{WIDTH{1'b0}}, i_data2};
   assign diff      = {1'b0, i_data1} - {1'b0, i_data2};

`ifdef SEQCALC_EARLY_TERM_EN
   // The current iteration consumes b_q[0]; if nothing above it is set, the
   // product is complete after this step.
   assign calc_last = (cnt_q == LAST_ITER) ||
                      ((op_q == OP_MUL) && (b_q[WIDTH-1:1] == '0));
`else
   assign calc_last = (cnt_q == LAST_ITER);
`endif

   assign o_busy = (state != ST_IDLE);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state         <= ST_IDLE;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         rem_q         <= '0;
         cnt_q         <= '0;
         o_done        <= 1'b0;
         o_result      <= '0;
         o_rem         <= '0;
         o_div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  op_q  <= i_op;
                  a_q   <= {{WIDTH{1'b0}}, i_data1};
                  b_q   <= i_data2;
                  acc_q <= '0;
                  rem_q <= '0;
                  cnt_q <= '0;
                  case (i_op)
                     OP_ADD: begin
                        o_result      <= sum;
                        o_rem         <= '0;
                        o_div_by_zero <= 1'b0;
                        o_done        <= 1'b1;
                        state         <= ST_DONE;
                     end
                     OP_SUB: begin
                        o_result      <= {{(WIDTH-1){1'b0}}, diff};
                        o_rem         <= '0;
                        o_div_by_zero <= 1'b0;
                        o_done        <= 1'b1;
                        state         <= ST_DONE;
                     end
                     OP_MUL: begin
`ifdef SEQCALC_EARLY_TERM_EN
                        if (i_data2 == '0) begin
                           o_result      <= '0;
                           o_rem         <= '0;
                           o_div_by_zero <= 1'b0;
                           o_done        <= 1'b1;
                           state         <= ST_DONE;
                        end else begin
                           state <= ST_CALC;
                        end
`else
                        state <= ST_CALC;
`endif
                     end
                     default: begin
                        if (i_data2 == '0) begin
                           o_result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                           o_rem         <= i_data1;
                           o_div_by_zero <= 1'b1;
                           o_done        <= 1'b1;
                           state         <= ST_DONE;
                        end else begin
                           state <= ST_CALC;
                        end
                     end
                  endcase
               end
            end

            ST_CALC: begin
               cnt_q <= cnt_q + 1'b1;
               a_q   <= a_q << 1;
               if (op_q == OP_MUL) begin
                  acc_q <= mul_next;
                  b_q   <= b_q >> 1;
               end else begin
                  acc_q <= quot_next;
                  rem_q <= step_rem;
               end
               if (calc_last) begin
                  o_result      <= (op_q == OP_MUL) ? mul_next : quot_next;
                  o_rem         <= (op_q == OP_MUL) ? '0 : step_rem;
                  o_div_by_zero <= 1'b0;
                  o_done        <= 1'b1;
                  state         <= ST_DONE;
               end
            end

            ST_DONE: begin
               o_done <= 1'b0;
               state  <= ST_IDLE;
            end

            default: begin
               o_done <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;

   localparam int W = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     op = 2'd0;
   logic [W-1:0]   d1 = '0;
   logic [W-1:0]   d2 = '0;
   logic           busy, done, dbz;
   logic [2*W-1:0] res;
   logic [W-1:0]   rem;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_calculator #(.WIDTH(W)) dut (
      .i_clk         (clk),
      .i_rstn        (rst_n),
      .i_start       (start),
      .i_op          (op),
      .i_data1       (d1),
      .i_data2       (d2),
      .o_busy        (busy),
      .o_done        (done),
      .o_result      (res),
      .o_rem         (rem),
      .o_div_by_zero (dbz)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   function automatic int exp_lat(input int o, input int b);
      if (o < 2) return 1;
      if (o == 3) return (b == 0) ? 1 : W + 1;
`ifdef SEQCALC_EARLY_TERM_EN
      if (b == 0) return 1;
      for (int i = W - 1; i >= 0; i--)
         if (((b >> i) & 1) == 1) return i + 2;
`endif
      return W + 1;
   endfunction

   function automatic logic [2*W-1:0] exp_res(input int o, input int a, input int b);
      int r;
      case (o)
         0: r = a + b;
         1: r = (a - b) & ((1 << (W + 1)) - 1);
         2: r = a * b;
         default: r = (b == 0) ? (1 << W) - 1 : a / b;
      endcase
      return (2*W)'(r);
   endfunction

   function automatic logic [W-1:0] exp_rem(input int o, input int a, input int b);
      if (o != 3) return '0;
      return (b == 0) ? W'(a) : W'(a % b);
   endfunction

   int             cyc = 0;
   bit             m_active = 0;
   int             m_done_cyc = 0;
   logic [2*W-1:0] p_res = '0, e_res = '0;
   logic [W-1:0]   p_rem = '0, e_rem = '0;
   logic           p_dbz = 1'b0, e_dbz = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0;
         e_res    = '0;
         e_rem    = '0;
         e_dbz    = 1'b0;
      end else begin
         bit was_busy;
         cyc++;
         was_busy = m_active;
         if (m_active && cyc > m_done_cyc) m_active = 0;
         if (!was_busy && start) begin
            m_active   = 1;
            m_done_cyc = cyc + exp_lat(int'(op), int'(d2)) - 1;
            p_res      = exp_res(int'(op), int'(d1), int'(d2));
            p_rem      = exp_rem(int'(op), int'(d1), int'(d2));
            p_dbz      = (op == 2'd3) && (d2 == '0);
         end
         if (m_active && cyc == m_done_cyc) begin
            e_res = p_res;
            e_rem = p_rem;
            e_dbz = p_dbz;
         end
      end
   end

   bit cmp_en = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_busy",   busy, m_active);
         chk("cyc_done",   done, m_active && (cyc == m_done_cyc));
         chk("cyc_result", res,  e_res);
         chk("cyc_rem",    rem,  e_rem);
         chk("cyc_dbz",    dbz,  e_dbz);
      end
   end

   // ---------------- directed transaction with literal expectations ----------------
   task automatic run_op(input logic [1:0] o, input int a, input int b,
                         input int exp_r, input int exp_m, input int exp_z,
                         input int exp_l, input bit inject, input string name);
      int n;
      @(posedge clk); #1;
      op = o; d1 = W'(a); d2 = W'(b); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); d1 = W'($urandom); d2 = W'($urandom);
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (inject && n == 2) begin
            start = 1'b1; op = 2'd0; d1 = W'(1); d2 = W'(1);
         end
         if (inject && n == 4) start = 1'b0;
         if (done) break;
         if (n >= 40) break;
      end
      chk({name, "_latency"}, n, exp_l);
      chk({name, "_result"}, res, exp_r);
      chk({name, "_rem"}, rem, exp_m);
      chk({name, "_dbz"}, dbz, exp_z);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", res, 0);
      chk("reset_rem", rem, 0);
      chk("reset_dbz", dbz, 0);
      cmp_en = 1;
      #1 rst_n = 1'b1;

      run_op(2'd0, 63, 63, 126, 0, 0, 1, 0, "add_63_63");
      run_op(2'd1, 5, 9, 124, 0, 0, 1, 0, "sub_5_9");
      run_op(2'd2, 63, 63, 3969, 0, 0, 7, 0, "mul_63_63");
`ifdef SEQCALC_EARLY_TERM_EN
      run_op(2'd2, 63, 1, 63, 0, 0, 2, 0, "mul_63_1");
      run_op(2'd2, 10, 10, 100, 0, 0, 5, 1, "mul_10_10_ignored_start");
`else
      run_op(2'd2, 63, 1, 63, 0, 0, 7, 0, "mul_63_1");
      run_op(2'd2, 10, 10, 100, 0, 0, 7, 1, "mul_10_10_ignored_start");
`endif
      run_op(2'd3, 45, 7, 6, 3, 0, 7, 0, "div_45_7");
      run_op(2'd3, 45, 0, 63, 45, 1, 1, 0, "div_45_0");
      run_op(2'd3, 63, 63, 1, 0, 0, 7, 0, "div_63_63");

      // Reset in the middle of a division.
      @(posedge clk); #1;
      op = 2'd3; d1 = W'(63); d2 = W'(5); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", res, 0);
      chk("abort_rem", rem, 0);
      repeat (2) begin
         @(negedge clk); #1;
         chk("abort_no_done", done, 0);
      end
      #1 rst_n = 1'b1;
      run_op(2'd0, 2, 3, 5, 0, 0, 1, 0, "add_after_reset");

      // Randomised traffic, start pulses land both idle and busy.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         start = ($urandom % 4 == 0);
         op    = 2'($urandom);
         d1    = ($urandom % 5 == 0) ? W'((1 << W) - 1) : W'($urandom);
         d2    = ($urandom % 6 == 0) ? W'(0) :
                 ($urandom % 5 == 0) ? W'((1 << W) - 1) : W'($urandom);
         if (i == 1500) begin
            start = 1'b0;
            @(negedge clk); #2;
            rst_n = 1'b0;
            @(negedge clk); #2;
            rst_n = 1'b1;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Multi-cycle unsigned arithmetic unit with start/done handshake; parametrised successor to the team's combinational add/sub/mul/div calculator.
- One operation per transaction: ADD, SUB, MUL or DIV, selected by opcode.
- MUL uses an iterative shift-add engine; DIV uses an iterative restoring engine. This removes the combinational multiplier/divider from the critical path.
- Sits between register-file/control logic and the result bus; results and flags are held until the next completion.

Parameters:
- WIDTH, 6: operand width in bits (min 2); results are 2*WIDTH wide.

Ports:
- i_clk, input, 1: single clock, rising edge.
- i_rstn, input, 1: asynchronous active-low reset.
- i_start, input, 1: request; sampled only in IDLE.
- i_op, input, 2: opcode; 0=ADD, 1=SUB, 2=MUL, 3=DIV.
- i_data1, input, WIDTH: operand A (dividend).
- i_data2, input, WIDTH: operand B (divisor).
- o_busy, input-independent output, 1: high whenever state is not IDLE.
- o_done, output, 1: one-cycle pulse when results become valid.
- o_result, output, 2*WIDTH: sum, difference, product or quotient, zero-extended.
- o_rem, output, WIDTH: DIV remainder; 0 for other ops.
- o_div_by_zero, output, 1: set with o_done when DIV has i_data2==0; cleared at next o_done.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rstn is asynchronous, active-low.
- Reset values: state=IDLE, o_busy=0, o_done=0, o_result=0, o_rem=0, o_div_by_zero=0, internal registers=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE, i_start=1: latch i_op, i_data1, i_data2.
    - ADD, SUB, or DIV with B==0 -> DONE.
    - MUL, or DIV with B!=0 -> CALC with iteration counter=0.
  - CALC: one iteration per cycle; after exactly WIDTH iterations -> DONE.
  - DONE: o_done=1 for this cycle only; outputs update on entry to DONE; -> IDLE unconditionally.
- Latency: if start is accepted at edge T, o_done is high:
  - cycle T+1 for ADD, SUB and DIV-by-zero;
  - cycle T+WIDTH+1 for MUL and DIV.
  - Throughput: the next start is accepted no earlier than the cycle after DONE.
- i_start while o_busy=1: ignored, no queuing. Operands are captured at acceptance, so later input changes have no effect.
- ADD: o_result = A+B zero-extended; bit WIDTH is the carry.
- SUB: o_result[WIDTH:0] = {0,A} - {0,B}, so bit WIDTH=1 indicates a borrow; upper bits are 0.
- MUL: shift-add over WIDTH iterations; o_result = A*B exact (max (2^WIDTH-1)^2 fits).
- DIV: restoring division, one quotient bit per iteration, MSB first.
  - o_result = floor(A/B) zero-extended; o_rem = A mod B.
- DIV, B==0: o_result = all ones in the low WIDTH bits (upper bits 0), o_rem = A, o_div_by_zero=1.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values; no o_done is produced for the aborted operation.
- Outputs other than o_done hold their last values until the next DONE.

Optional Feature:
- Macro SEQCALC_EARLY_TERM_EN.
- Defined: MUL leaves CALC as soon as the remaining multiplier bits are all zero. For B==0 it goes straight to DONE (o_done at T+1). The result is unchanged and latency becomes (index of highest set bit of B)+2.
- Not defined: MUL always takes the fixed WIDTH iterations.
- DIV latency is unaffected either way.

Decomposition:
- Package seq_calc_pkg:
  - op constants OP_ADD, OP_SUB, OP_MUL, OP_DIV (2 bits);
  - state encodings ST_IDLE, ST_CALC, ST_DONE;
  - counter width function clog2(WIDTH+1).
- Sub-module seq_calc_divstep: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once and iterated by the FSM.
- Top level: FSM, operand/accumulator shift registers, counter, output registers.

Test Plan (WIDTH=6):
- ADD, A=63, B=63, start at T -> o_done at T+1, o_result=126, o_rem=0, o_busy high only during cycle T+1.
- SUB, A=5, B=9 -> o_result=0x07C (bit 6 borrow=1, low bits 60), o_done at T+1.
- MUL, A=63, B=63 -> o_result=3969 with o_done at exactly T+7. With SEQCALC_EARLY_TERM_EN and A=63, B=1 -> o_result=63, o_done at T+2.
- DIV, A=45, B=7 -> o_result=6, o_rem=3, o_div_by_zero=0, o_done at T+7. Then DIV, A=45, B=0 -> o_result=63, o_rem=45, o_div_by_zero=1 at T+1.
- MUL 10*10 started; at T+3 apply i_start with ADD 1+1 and changed operands -> ignored; o_result=100 at T+7, only one o_done pulse.
- DIV 63/5 started; assert i_rstn=0 at T+3 for 2 cycles -> all outputs 0 immediately, no o_done. After release, ADD 2+3 -> o_result=5 at T'+1.
